// File: rtl/mio_defs.sv
// Shared definitions for the MIO data-side responder: FSM state encoding,
// wait-counter width and the default RAM address width.
package mio_defs;

  localparam int MIO_CNT_W          = 4;
  localparam int MIO_ADDR_WIDTH_DEF = 10;
  localparam int MIO_DATA_W         = 32;

  typedef enum logic [1:0] {
    MIO_IDLE = 2'd0,
    MIO_WAIT = 2'd1,
    MIO_DONE = 2'd2
  } mio_state_t;

endpackage

// File: rtl/mio_ram_core.sv
// Synchronous single-port word RAM. The write happens and the read data is
// registered on the same access edge; dout holds between reads.
module mio_ram_core
  import mio_defs::*;
#(
  parameter int ADDR_WIDTH = MIO_ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [MIO_DATA_W-1:0] din,
  output logic [MIO_DATA_W-1:0] dout
);

  logic [MIO_DATA_W-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

  // Write port.
  // NOTE: the array has no reset branch on purpose; contents survive reset and the array maps onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= din;
    end
  end

  // Registered read data, updated only by a read access so it holds the last value read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
    end else if (en && !we) begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/mio_data_responder.sv
// Data-side memory/IO responder for the SCPU bus. Accepts one word request,
// waits WAIT_CYCLES, accesses the internal RAM and pulses MIO_ready for one cycle.
// Optional build macro: MIO_ALIGN_CHECK_EN -- misaligned requests skip the RAM
// access and complete with bus_err set; otherwise Addr_in[1:0] is ignored.
module mio_data_responder
  import mio_defs::*;
#(
  parameter int ADDR_WIDTH  = MIO_ADDR_WIDTH_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_wr,
  output logic [31:0] Data_rd,
  output logic        MIO_ready,
  output logic        bus_err
);

  localparam int                   IDX_HI    = ADDR_WIDTH + 1;
  localparam bit                   NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [MIO_CNT_W-1:0] WAIT_LOAD = MIO_CNT_W'(WAIT_CYCLES);
  localparam logic [MIO_CNT_W-1:0] CNT_ONE   = MIO_CNT_W'(1);

  mio_state_t           state;
  logic [MIO_CNT_W-1:0] wait_cnt;
  logic                 req_we;
  logic [IDX_HI:0]      req_addr;
  logic [31:0]          req_data;
  logic                 ready_q;
  logic                 err_q;

  logic                 cur_we;
  logic [IDX_HI:0]      cur_addr;
  logic [31:0]          cur_data;
  logic                 access_now;
  logic                 misaligned;
  logic                 ram_en;

  // Address bits above the word index alias away; low bits matter only with the alignment check.
  logic                 unused_addr_bits;
  assign unused_addr_bits = ^{Addr_in[31:IDX_HI+1], cur_addr[1:0]};

  // Pick the live request in IDLE (a zero-wait access fires on the accept edge), else the latched one.
  always_comb begin
    // NOTE: every output of this block is assigned up front on all paths, so no latch can be inferred.
    cur_we     = req_we;
    cur_addr   = req_addr;
    cur_data   = req_data;
    access_now = 1'b0;
    if (state == MIO_IDLE) begin
      cur_we     = mem_w;
      cur_addr   = Addr_in[IDX_HI:0];
      cur_data   = Data_wr;
      access_now = CPU_MIO && NO_WAIT;
    end else if (state == MIO_WAIT) begin
      access_now = (wait_cnt == CNT_ONE);
    end
`ifdef MIO_ALIGN_CHECK_EN
    misaligned = |cur_addr[1:0];
`else
    misaligned = 1'b0;
`endif
    ram_en = access_now && !misaligned;
  end

  mio_ram_core #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .en   (ram_en),
    .we   (cur_we),
    .addr (cur_addr[IDX_HI:2]),
    .din  (cur_data),
    .dout (Data_rd)
  );

  // Request FSM and wait counter; completion flags are registered and raised on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MIO_IDLE;
      wait_cnt <= '0;
      req_we   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        MIO_IDLE: begin
          if (CPU_MIO) begin
            req_we   <= mem_w;
            req_addr <= Addr_in[IDX_HI:0];
            req_data <= Data_wr;
            wait_cnt <= WAIT_LOAD;
            if (NO_WAIT) begin
              state   <= MIO_DONE;
              ready_q <= 1'b1;
              err_q   <= misaligned;
            end else begin
              state <= MIO_WAIT;
            end
          end
        end
        MIO_WAIT: begin
          wait_cnt <= wait_cnt - CNT_ONE;
          if (wait_cnt == CNT_ONE) begin
            state   <= MIO_DONE;
            ready_q <= 1'b1;
            err_q   <= misaligned;
          end
        end
        MIO_DONE: begin
          state <= MIO_IDLE;
        end
        default: begin
          state <= MIO_IDLE;
        end
      endcase
    end
  end

  assign MIO_ready = ready_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_mio_data_responder.sv
// Self-checking bench for mio_data_responder: scoreboard of expected
// completions fed by the driver, checked by an independent monitor, plus a
// zero-wait instance exercised with directed checks.
`timescale 1ns/1ps
module tb_mio_data_responder;

  localparam int AW          = 10;
  localparam int W           = 2;
  localparam int ALIAS_BYTES = 4 * (1 << AW);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance under scoreboard, WAIT_CYCLES = 2
  logic        a_mio = 1'b0, a_w = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic [31:0] a_rdata;
  logic        a_ready, a_err;

  mio_data_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .CPU_MIO(a_mio), .mem_w(a_w), .Addr_in(a_addr),
    .Data_wr(a_wdata), .Data_rd(a_rdata), .MIO_ready(a_ready), .bus_err(a_err)
  );

  // Zero-wait instance
  logic        z_mio = 1'b0, z_w = 1'b0;
  logic [31:0] z_addr = '0, z_wdata = '0;
  logic [31:0] z_rdata;
  logic        z_ready, z_err;

  mio_data_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .CPU_MIO(z_mio), .mem_w(z_w), .Addr_in(z_addr),
    .Data_wr(z_wdata), .Data_rd(z_rdata), .MIO_ready(z_ready), .bus_err(z_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [int];
  logic [31:0] model_rd = '0;

  function automatic bit is_misaligned(input logic [31:0] addr);
`ifdef MIO_ALIGN_CHECK_EN
    return (addr % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr % ALIAS_BYTES) / 4);
  endfunction

  task automatic model_apply(input logic we, input logic [31:0] addr, input logic [31:0] data,
                             output exp_t e);
    e.err = is_misaligned(addr);
    if (!e.err) begin
      if (we) model_mem[word_of(addr)] = data;
      else    model_rd = model_mem.exists(word_of(addr)) ? model_mem[word_of(addr)] : 32'hx;
    end
    e.rd  = model_rd;
    e.cyc = 0;
  endtask

  // ---------------- monitor ----------------
  logic a_ready_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (a_ready) begin
      check("ready_width", {31'b0, a_ready_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: MIO_ready high at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = exp_q.pop_front();
        check("ready_cycle", cyc, e.cyc);
        check("rd_data", a_rdata, e.rd);
        check("bus_err", {31'b0, a_err}, {31'b0, e.err});
      end
    end
    a_ready_prev <= a_ready;
  end

  // ---------------- driver ----------------
  // Called on a negedge: either with the DUT idle, or (b2b) on the negedge where
  // the previous MIO_ready was seen, holding CPU_MIO high.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input bit b2b, input bit drop_early);
    exp_t e;
    int   acc;
    bit   seen;
    seen    = 1'b0;
    a_mio   = 1'b1;
    a_w     = we;
    a_addr  = addr;
    a_wdata = data;
    acc     = b2b ? cyc + 2 : cyc + 1;
    model_apply(we, addr, data, e);
    e.cyc = acc + W;
    exp_q.push_back(e);
    if (drop_early) begin
      for (int i = 0; i < 4 && cyc < acc; i++) @(negedge clk);
      a_mio   = 1'b0;
      a_w     = ~we;
      a_addr  = $urandom;
      a_wdata = $urandom;
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = a_ready;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: no MIO_ready within 40 cycles for addr %h", addr);
    end
  endtask

  task automatic gap(input int n);
    a_mio   = 1'b0;
    a_w     = $urandom;
    a_addr  = $urandom;
    a_wdata = $urandom;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          idx;
    logic [31:0] addr;
    logic        we;
    bit          b2b;
    bit          drop;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_a_ready", {31'b0, a_ready}, 32'd0);
    check("rst_a_err",   {31'b0, a_err},   32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_z_rdata", z_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Zero wait states: completion in the cycle right after the sampling edge, one cycle wide
    z_mio = 1'b1; z_w = 1'b1; z_addr = 32'h40; z_wdata = 32'hCAFEF00D;
    @(negedge clk);
    check("z_wr_ready", {31'b0, z_ready}, 32'd1);
    check("z_wr_rdata_held", z_rdata, 32'd0);
    z_mio = 1'b0;
    @(negedge clk);
    check("z_wr_width", {31'b0, z_ready}, 32'd0);
    z_mio = 1'b1; z_w = 1'b0; z_addr = 32'h40;
    @(negedge clk);
    check("z_rd_ready", {31'b0, z_ready}, 32'd1);
    check("z_rd_data", z_rdata, 32'hCAFEF00D);
    z_mio = 1'b0; z_addr = 32'h0; z_w = 1'b1;
    @(negedge clk);
    check("z_rd_width", {31'b0, z_ready}, 32'd0);
    check("z_rd_hold", z_rdata, 32'hCAFEF00D);

    // Write then read
    issue(1'b1, 32'h0000000C, 32'h5A5AA5A5, 1'b0, 1'b0); gap(1);
    issue(1'b0, 32'h0000000C, 32'h0,        1'b0, 1'b0); gap(2);

    // Address aliasing modulo 4 KiB
    issue(1'b1, 32'h00001000, 32'h12345678, 1'b0, 1'b0); gap(1);
    issue(1'b0, 32'h00000000, 32'h0,        1'b0, 1'b0); gap(1);

    // Reset in the middle of a wait: write aborted, outputs cleared
    issue(1'b1, 32'h00000010, 32'h0BADC0DE, 1'b0, 1'b0); gap(1);
    a_mio = 1'b1; a_w = 1'b1; a_addr = 32'h10; a_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    a_mio = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_ready", {31'b0, a_ready}, 32'd0);
    check("midrst_err",   {31'b0, a_err},   32'd0);
    check("midrst_rdata", a_rdata, 32'd0);
    model_rd = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_ready", {31'b0, a_ready}, 32'd0);
    end
    reset = 1'b0;
    gap(1);
    issue(1'b0, 32'h00000010, 32'h0, 1'b0, 1'b0); gap(1);

    // CPU_MIO dropped and inputs scrambled mid-wait: transaction still completes
    issue(1'b1, 32'h00000014, 32'h600DF00D, 1'b0, 1'b1); gap(1);
    issue(1'b0, 32'h00000014, 32'h0,        1'b0, 1'b0); gap(1);

    // Back-to-back: two writes then a read with CPU_MIO held high
    issue(1'b1, 32'h00000020, 32'hAAAA0001, 1'b0, 1'b0);
    issue(1'b1, 32'h00000020, 32'hBBBB0002, 1'b1, 1'b0);
    issue(1'b0, 32'h00000020, 32'h0,        1'b1, 1'b0); gap(1);

    // Misaligned write, then read of the containing word
    issue(1'b1, 32'h0000000D, 32'hDEADBEEF, 1'b0, 1'b0); gap(1);
    issue(1'b0, 32'h0000000C, 32'h0,        1'b0, 1'b0); gap(1);

    // Randomized traffic with aliasing, misalignment, gaps, back-to-back and early drops
    for (int t = 0; t < 60; t++) begin
      idx  = $urandom_range(0, 15);
      addr = 32'(idx * 4 + ALIAS_BYTES * $urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) addr = addr + 32'($urandom_range(1, 3));
      we = 1'($urandom_range(0, 1));
      if (!we && !model_mem.exists(word_of(addr))) we = 1'b1;
      b2b  = (t > 0) && ($urandom_range(0, 2) == 0);
      drop = ($urandom_range(0, 3) == 0);
      if (!b2b) gap($urandom_range(1, 3));
      issue(we, addr, $urandom, b2b, drop);
    end

    gap(4);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mio_data_responder.md
Name: mio_data_responder

Overview:
- Memory/IO bus responder at the far end of the SCPU data port (Addr_out, Data_out, mem_w, CPU_MIO, MIO_ready, Data_in).
- Accepts word read/write requests from the CPU, inserts a parameterised number of wait states, and performs the access on an internal word-addressed RAM.
- Returns read data and pulses MIO_ready for one cycle to complete each transaction.
- Replaces the fixed Data_in constant used in CPU benches with a real data-side slave.

Parameters:
ADDR_WIDTH, 10, log2 of RAM depth in 32-bit words (1024 words).
WAIT_CYCLES, 2, wait states between request acceptance and access; 0..15 legal.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
CPU_MIO  input  1  request valid; held high by the CPU until MIO_ready is seen.
mem_w  input  1  1 = write, 0 = read; stable while CPU_MIO is high.
Addr_in  input  32  byte address from the CPU (Addr_out).
Data_wr  input  32  write data from the CPU (Data_out).
Data_rd  output  32  read data to the CPU (Data_in).
MIO_ready  output  1  one-cycle completion pulse.
bus_err  output  1  error flag, valid with MIO_ready.

Behaviour:
- Reset (async, active-high): state=IDLE, wait counter=0, MIO_ready=0, bus_err=0, Data_rd=0. RAM contents are not cleared.
- States: IDLE, WAIT, DONE.
- IDLE:
  - CPU_MIO=1 at a clock edge: latch mem_w, Addr_in and Data_wr; load counter=WAIT_CYCLES.
  - Counter nonzero: go to WAIT.
  - WAIT_CYCLES=0: perform the access on this edge and go to DONE.
- WAIT: decrement the counter each cycle. On the edge where the counter reaches 1, perform the access and go to DONE.
- Access:
  - Word index = latched Addr[ADDR_WIDTH+1:2]. Address bits above this are ignored, so addresses alias modulo 4*2^ADDR_WIDTH.
  - Write: RAM[index] <= latched data; Data_rd unchanged.
  - Read: Data_rd <= RAM[index], registered.
- DONE:
  - MIO_ready=1 for exactly one cycle; Data_rd is valid in this cycle.
  - Next state is IDLE unconditionally.
- Latency: request sampled at edge N → MIO_ready high during cycle N+WAIT_CYCLES+1.
- Back-to-back: if CPU_MIO is still high in IDLE after DONE, it is accepted as a new request. Minimum spacing between MIO_ready pulses is WAIT_CYCLES+2 cycles.
- Data_rd holds the last read value until the next read completes.
- Changes on the inputs after latching are ignored until the transaction finishes.
- Reset mid-WAIT: transaction aborted, no RAM write, no MIO_ready pulse.
- CPU_MIO dropped mid-WAIT: the transaction still completes, including the write and the MIO_ready pulse.

Optional Feature:
- Macro: MIO_ALIGN_CHECK_EN.
- Defined:
  - Latched Addr[1:0] != 0 means no RAM access and Data_rd is unchanged.
  - MIO_ready and bus_err both pulse in DONE. Latency is unchanged.
- Undefined: Addr[1:0] ignored; bus_err tied 0.

Decomposition:
- Shared package/header mio_defs holds:
  - state encodings MIO_IDLE=2'd0, MIO_WAIT=2'd1, MIO_DONE=2'd2;
  - counter width constant MIO_CNT_W=4;
  - default ADDR_WIDTH.
- One sub-module, mio_ram_core:
  - synchronous single-port word RAM (clk, we, addr, din, dout);
  - read data registered on the access edge.
- FSM and wait counter stay in the top module.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - Write 0x5A5AA5A5 to 0x0000000C → MIO_ready 3 cycles after request.
  - Read 0x0C → Data_rd=0x5A5AA5A5 with MIO_ready.
- WAIT_CYCLES=0:
  - Read → MIO_ready in the cycle right after the sampling edge.
  - Pulse is exactly 1 cycle wide.
- Aliasing, ADDR_WIDTH=10: write 0x12345678 to 0x00001000, read 0x00000000 → Data_rd=0x12345678.
- Reset mid-WAIT:
  - Write 0xFFFFFFFF to 0x10, assert reset one cycle after acceptance → no MIO_ready, all outputs 0.
  - Subsequent read of 0x10 → old value.
- Back-to-back, WAIT_CYCLES=2, CPU_MIO held high across two writes then one read → MIO_ready pulses exactly 4 cycles apart, read returns the second write's data.
- MIO_ALIGN_CHECK_EN defined:
  - Write 0xDEADBEEF to 0x0D → MIO_ready=1 and bus_err=1 together.
  - Read 0x0C → unchanged contents.
